enc_qpsk: RTL and testbench
===========================

ENC_QPSK -- requirements
Module: enc_qpsk

Interface
REQ-001 SHALL have parameter SPS, default 8: samples per symbol, legal range 4..256.
REQ-002 SHALL have parameter AMP, default 8'd90: symbol amplitude magnitude, legal range 1..127.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bit_in  input  1  serial data bit, e.g. the m-sequence output.
REQ-006 SHALL have port bit_valid  input  1  bit_in is valid this cycle.
REQ-007 SHALL have port bit_ready  output  1  encoder accepts bit_in this cycle.
REQ-008 SHALL have port dataI  output  8  signed two's-complement in-phase sample.
REQ-009 SHALL have port dataQ  output  8  signed two's-complement quadrature sample.
REQ-010 SHALL have port sym_strobe  output  1  one-cycle pulse on the first sample of each symbol.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse when a symbol ends with no next symbol pending.
REQ-012 SHALL have port sym_cnt  output  8  count of emitted symbols, wraps 255->0.

Function
REQ-013 SHALL accept a bit on a rising edge where bit_valid && bit_ready.
REQ-014 SHALL assign the first accepted bit of a pair to I and the second to Q, tracked by a 1-bit phase flag.
REQ-015 SHALL, on acceptance of the Q bit, load the dibit into a pending register and set pend_valid.
REQ-016 SHALL drive bit_ready = !pend_valid, registered, with no combinational path from bit_valid.
REQ-017 SHALL map bit 0 -> +AMP and bit 1 -> -AMP, independently on I and Q (Gray QPSK).
REQ-018 SHALL implement emitter FSM states IDLE and RUN, with a sample counter 0..SPS-1.
REQ-019 IDLE: SHALL drive dataI = dataQ = 8'h00 and, if pend_valid, load the symbol, clear pend_valid, set counter 0, pulse sym_strobe and go to RUN.
REQ-020 RUN: SHALL hold dataI/dataQ constant and increment the counter each cycle.
REQ-021 RUN at counter SPS-1 with pend_valid: SHALL load the next symbol, reset the counter, and pulse sym_strobe, with no gap sample.
REQ-022 RUN at counter SPS-1 without pend_valid: SHALL go to IDLE, output 8'h00 on the next cycle, and pulse underrun.
REQ-023 SHALL have a latency of 2 cycles from the edge accepting the Q bit (IDLE case) to dataI/dataQ/sym_strobe valid at the outputs.
REQ-024 SHALL, when pend_valid clears and a new bit arrives on the same edge, accept that bit on the following edge only, because bit_ready is registered.
REQ-025 SHALL increment sym_cnt on each sym_strobe, modulo 256.
REQ-026 SHALL sustain continuous output with no underrun for a source holding bit_valid high, given SPS>=4.
REQ-027 SHALL keep all outputs registered.

Reset
REQ-028 On rst: SHALL set FSM=IDLE, counter=0, phase flag=I, pend_valid=0, bit_ready=1 (after reset release), dataI=dataQ=8'h00, sym_strobe=0, underrun=0, sym_cnt=0.
REQ-029 SHALL discard a half-collected dibit or an in-flight symbol when rst is asserted mid-operation, with no underrun pulse.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, RUN) and the bit-to-amplitude mapping constants in shared package qpsk_pkg, for reuse by dec_qpsk.
REQ-031 SHALL implement the bit collector (phase flag, pending register, ready) as sub-module dibit_collect; the emitter FSM SHALL live in enc_qpsk.

Verification
REQ-032 Reset, then bits 0,0 -> after SPS=8: 8 samples dataI=dataQ=8'sd90, one sym_strobe, then underrun pulse and 8'h00, sym_cnt=1.
REQ-033 Bits 1,0 -> dataI=-90 (8'hA6), dataQ=+90 (8'h5A); bits 0,1 -> dataI=8'h5A, dataQ=8'hA6.
REQ-034 Continuous 31-bit m-sequence stream with bit_valid stuck at 1 -> no underrun, sym_strobe every 8 cycles, no 8'h00 samples between symbols.
REQ-035 Stream 257 symbols -> sym_cnt reads 1 after wrap, with 255->0 observed.
REQ-036 Assert rst after a lone I bit and mid-symbol at counter 3 -> outputs 8'h00, next pair starts a fresh I/Q alignment, no underrun pulse.
REQ-037 SPS=4 with bit_valid toggled 1/0 -> check bit_ready deasserts while pend_valid=1 and no bit is lost or duplicated against a reference queue.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: emitter state encoding and the Gray bit-to-amplitude mapping.
// Used by the encoder here and by the matching decoder.
package qpsk_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } emit_state_t;

    localparam logic [7:0] SAMPLE_ZERO = 8'h00;
    localparam logic       BIT_POS     = 1'b0;   // this bit value maps to +AMP
    localparam logic       PHASE_I     = 1'b0;
    localparam logic       PHASE_Q     = 1'b1;

    function automatic logic [7:0] map_bit(input logic b, input logic [7:0] amp);
        if (b == BIT_POS) begin
            map_bit = amp;
        end else begin
            map_bit = 8'h00 - amp;
        end
    endfunction

endpackage

// File: rtl/dibit_collect.sv
// Serial bit collector: pairs bits into an I/Q dibit and holds it in a one-deep
// pending register until the emitter takes it. Ready is registered.
module dibit_collect
    import qpsk_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    input  logic       i_pend_take,
    output logic       o_bit_ready,
    output logic       o_pend_valid,
    output logic [1:0] o_pend_dibit
);

    logic       r_phase;
    logic       r_i_bit;
    logic       r_pend_valid;
    logic [1:0] r_pend_dibit;
    logic       r_ready;
    logic       w_accept;
    logic       w_pend_valid_nxt;

    // Take and Q-accept never coincide: a take implies pending full, hence ready low.
    always_comb begin
        w_accept         = i_bit_valid && r_ready;
        w_pend_valid_nxt = r_pend_valid;
        if (i_pend_take) begin
            w_pend_valid_nxt = 1'b0;
        end else if (w_accept && (r_phase == PHASE_Q)) begin
            w_pend_valid_nxt = 1'b1;
        end else begin
            w_pend_valid_nxt = r_pend_valid;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase      <= PHASE_I;
            r_i_bit      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_dibit <= 2'b00;
            r_ready      <= 1'b1;
        end else begin
            r_pend_valid <= w_pend_valid_nxt;
            r_ready      <= !w_pend_valid_nxt;
            if (w_accept) begin
                if (r_phase == PHASE_I) begin
                    r_i_bit <= i_bit;
                end else begin
                    r_pend_dibit <= {r_i_bit, i_bit};
                end
                r_phase <= !r_phase;
            end
        end
    end

    assign o_bit_ready  = r_ready;
    assign o_pend_valid = r_pend_valid;
    assign o_pend_dibit = r_pend_dibit;

endmodule

// File: rtl/enc_qpsk.sv
// QPSK symbol encoder: collects dibits from a serial stream and emits each symbol
// as SPS constant I/Q samples, with strobe, underrun and symbol-count outputs.
module enc_qpsk
    import qpsk_pkg::*;
#(
    parameter int         SPS = 8,
    parameter logic [7:0] AMP = 8'd90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [7:0] dataI,
    output logic [7:0] dataQ,
    output logic       sym_strobe,
    output logic       underrun,
    output logic [7:0] sym_cnt
);

    localparam int             CW       = $clog2(SPS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SPS - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    emit_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_sym, w_sym_nxt;
    logic          r_end_evt, w_end_evt;
    logic          w_take;
    logic          w_pend_valid;
    logic [1:0]    w_pend_dibit;

    logic [7:0]    r_data_i, r_data_q, r_sym_cnt;
    logic          r_strobe, r_underrun;
    logic [7:0]    w_data_i_nxt, w_data_q_nxt, w_sym_cnt_nxt;
    logic          w_strobe_nxt;

    dibit_collect u_collect (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_bit        (bit_in),
        .i_bit_valid  (bit_valid),
        .i_pend_take  (w_take),
        .o_bit_ready  (bit_ready),
        .o_pend_valid (w_pend_valid),
        .o_pend_dibit (w_pend_dibit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_sym     <= 2'b00;
            r_end_evt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sym     <= w_sym_nxt;
            r_end_evt <= w_end_evt;
        end
    end

    // A pending dibit is taken on the last sample so the next symbol follows without a gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sym_nxt   = r_sym;
        w_take      = 1'b0;
        w_end_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                    w_sym_nxt   = w_pend_dibit;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_pend_valid) begin
                        w_take    = 1'b1;
                        w_sym_nxt = w_pend_dibit;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_end_evt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        w_data_i_nxt = SAMPLE_ZERO;
        w_data_q_nxt = SAMPLE_ZERO;
        w_strobe_nxt = 1'b0;
        if (r_state == ST_RUN) begin
            w_data_i_nxt = map_bit(r_sym[1], AMP);
            w_data_q_nxt = map_bit(r_sym[0], AMP);
            w_strobe_nxt = (r_cnt == CNT_ZERO);
        end else begin
            w_strobe_nxt = 1'b0;
        end
        if (w_strobe_nxt) begin
            w_sym_cnt_nxt = r_sym_cnt + 8'd1;
        end else begin
            w_sym_cnt_nxt = r_sym_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_i   <= SAMPLE_ZERO;
            r_data_q   <= SAMPLE_ZERO;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
            r_sym_cnt  <= 8'd0;
        end else begin
            r_data_i   <= w_data_i_nxt;
            r_data_q   <= w_data_q_nxt;
            r_strobe   <= w_strobe_nxt;
            r_underrun <= r_end_evt;
            r_sym_cnt  <= w_sym_cnt_nxt;
        end
    end

    assign dataI      = r_data_i;
    assign dataQ      = r_data_q;
    assign sym_strobe = r_strobe;
    assign underrun   = r_underrun;
    assign sym_cnt    = r_sym_cnt;

endmodule

// File: tb/tb_enc_qpsk.sv
// Bench for enc_qpsk: SPS=8 and SPS=4 instances share stimulus; each is compared every
// cycle against a timeline model (symbol start times computed from acceptance edges).
module tb_enc_qpsk;

    localparam int SPS_A = 8;
    localparam int SPS_B = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in, bit_valid;
    logic       a_ready, a_strobe, a_under, b_ready, b_strobe, b_under;
    logic [7:0] a_di, a_dq, a_cnt, b_di, b_dq, b_cnt;

    int vecs, errs;

    always #5 clk = ~clk;

    enc_qpsk #(.SPS(SPS_A), .AMP(8'd90)) u_dut8 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(a_ready),
        .dataI(a_di), .dataQ(a_dq), .sym_strobe(a_strobe), .underrun(a_under), .sym_cnt(a_cnt));

    enc_qpsk #(.SPS(SPS_B), .AMP(8'd90)) u_dut4 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(b_ready),
        .dataI(b_di), .dataQ(b_dq), .sym_strobe(b_strobe), .underrun(b_under), .sym_cnt(b_cnt));

    // Model state, index 0 = SPS 8 instance, 1 = SPS 4 instance.
    int   n;
    int   sps [2];
    logic phase [2];
    logic ibit [2];
    int   q_start [2][4];
    logic q_i [2][4];
    logic q_q [2][4];
    int   q_head [2], q_tail [2], last_end [2], busy_from [2], busy_to [2];
    int   ended_at [2], started [2], pairs [2];
    logic [7:0] prev_cnt;
    logic wrapped;
    int   under_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [7:0] amp_of(input logic b);
        return b ? 8'd166 : 8'd90;   // 166 == -90 in two's complement
    endfunction

    function automatic logic exp_ready(input int k);
        return !(n >= busy_from[k] && n <= busy_to[k]);
    endfunction

    task automatic model_reset();
        n = 0;
        sps[0] = SPS_A;
        sps[1] = SPS_B;
        for (int k = 0; k < 2; k++) begin
            phase[k] = 1'b0; ibit[k] = 1'b0;
            q_head[k] = 0; q_tail[k] = 0; last_end[k] = 0;
            busy_from[k] = 1; busy_to[k] = 0; ended_at[k] = -1;
            started[k] = 0; pairs[k] = 0;
        end
        prev_cnt = 8'd0;
    endtask

    task automatic model_edge(input int k, input logic acc, input logic b);
        int st;
        if (acc) begin
            if (!phase[k]) begin
                ibit[k]  = b;
                phase[k] = 1'b1;
            end else begin
                phase[k] = 1'b0;
                st = (n + 2 > last_end[k]) ? n + 2 : last_end[k];
                q_start[k][q_tail[k] % 4] = st;
                q_i[k][q_tail[k] % 4]     = ibit[k];
                q_q[k][q_tail[k] % 4]     = b;
                q_tail[k]++;
                last_end[k]  = st + sps[k];
                busy_from[k] = n;
                busy_to[k]   = st - 2;
                pairs[k]++;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [7:0] di, input logic [7:0] dq, input logic st,
                             input logic ur, input logic [7:0] cnt, input logic rdy);
        logic       front, e_st, e_ur;
        logic [7:0] e_di, e_dq;
        string      nm;
        nm = (k == 0) ? "sps8" : "sps4";
        while (q_tail[k] > q_head[k] && q_start[k][q_head[k] % 4] + sps[k] <= n) begin
            ended_at[k] = q_start[k][q_head[k] % 4] + sps[k];
            q_head[k]++;
        end
        front = (q_tail[k] > q_head[k]) && (q_start[k][q_head[k] % 4] <= n);
        e_di  = front ? amp_of(q_i[k][q_head[k] % 4]) : 8'h00;
        e_dq  = front ? amp_of(q_q[k][q_head[k] % 4]) : 8'h00;
        e_st  = front && (q_start[k][q_head[k] % 4] == n);
        if (e_st) started[k]++;
        e_ur  = (ended_at[k] == n) && !e_st;
        check_eq({nm, ".dataI"}, 32'(di), 32'(e_di));
        check_eq({nm, ".dataQ"}, 32'(dq), 32'(e_dq));
        check_eq({nm, ".strobe"}, 32'(st), 32'(e_st));
        check_eq({nm, ".underrun"}, 32'(ur), 32'(e_ur));
        check_eq({nm, ".sym_cnt"}, 32'(cnt), 32'(started[k] % 256));
        check_eq({nm, ".bit_ready"}, 32'(rdy), 32'(exp_ready(k)));
        if (k == 0) begin
            if (prev_cnt == 8'd255 && cnt == 8'd0) wrapped = 1'b1;
            prev_cnt = cnt;
            if (ur) under_seen++;
        end
    endtask

    task automatic cycle(input logic v, input logic b, output logic acc_a);
        logic acc0, acc1;
        bit_valid = v;
        bit_in    = b;
        acc0 = v && exp_ready(0);
        acc1 = v && exp_ready(1);
        acc_a = acc0;
        @(posedge clk);
        n++;
        model_edge(0, acc0, b);
        model_edge(1, acc1, b);
        @(negedge clk);
        check_dut(0, a_di, a_dq, a_strobe, a_under, a_cnt, a_ready);
        check_dut(1, b_di, b_dq, b_strobe, b_under, b_cnt, b_ready);
    endtask

    task automatic idle(input int cycles);
        logic dummy;
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, dummy);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, ".sps8.dataI"}, 32'(a_di), 32'h0);
        check_eq({tag, ".sps8.dataQ"}, 32'(a_dq), 32'h0);
        check_eq({tag, ".sps8.strobe"}, 32'(a_strobe), 32'h0);
        check_eq({tag, ".sps8.underrun"}, 32'(a_under), 32'h0);
        check_eq({tag, ".sps8.sym_cnt"}, 32'(a_cnt), 32'h0);
        check_eq({tag, ".sps4.dataI"}, 32'(b_di), 32'h0);
        check_eq({tag, ".sps4.underrun"}, 32'(b_under), 32'h0);
        check_eq({tag, ".sps4.sym_cnt"}, 32'(b_cnt), 32'h0);
    endtask

    // Called at a falling edge: assert reset asynchronously, hold one edge, release.
    task automatic do_reset(input string tag);
        bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_zero_outputs({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs({tag, ".hold"});
        rst = 1'b0;
        model_reset();
        #1;
        check_eq({tag, ".sps8.ready"}, 32'(a_ready), 32'h1);
        check_eq({tag, ".sps4.ready"}, 32'(b_ready), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic [4:0] lfsr;
        int         nacc;
        vecs = 0; errs = 0; wrapped = 1'b0; under_seen = 0;
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("por");
        rst = 1'b0;
        #1;
        check_eq("por.sps8.ready", 32'(a_ready), 32'h1);
        check_eq("por.sps4.ready", 32'(b_ready), 32'h1);

        // Single symbol 0,0 then underrun back to zero.
        cycle(1'b1, 1'b0, acc);
        cycle(1'b1, 1'b0, acc);
        idle(14);
        check_eq("single.sps8.sym_cnt", 32'(a_cnt), 32'h1);

        // Mixed-sign symbols.
        cycle(1'b1, 1'b1, acc); cycle(1'b1, 1'b0, acc); idle(12);
        cycle(1'b1, 1'b0, acc); cycle(1'b1, 1'b1, acc); idle(12);

        // Continuous m-sequence with valid held high; source holds a bit until accepted.
        lfsr = 5'h01; nacc = 0; under_seen = 0;
        for (int c = 0; c < 600 && nacc < 62; c++) begin
            cycle(1'b1, lfsr[0], acc);
            if (acc) begin
                lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
                nacc++;
            end
        end
        check_eq("mseq.underruns", 32'(under_seen), 32'h0);
        idle(12);

        // 257 symbols from reset: counter wraps through 255->0 and ends at 1.
        do_reset("pre_wrap");
        wrapped = 1'b0;
        for (int c = 0; c < 6000 && pairs[0] < 257; c++) cycle(1'b1, 1'($urandom), acc);
        idle(30);
        check_eq("wrap.seen", 32'(wrapped), 32'h1);
        check_eq("wrap.sym_cnt", 32'(a_cnt), 32'h1);

        // Reset after a lone I bit, then mid-symbol.
        cycle(1'b1, 1'b1, acc);
        do_reset("lone_i");
        cycle(1'b1, 1'b0, acc);
        cycle(1'b1, 1'b1, acc);
        idle(5);
        do_reset("mid_sym");
        idle(12);

        // Valid toggling 1/0 with random data.
        for (int c = 0; c < 120; c++) cycle(1'(c % 2 == 0), 1'($urandom), acc);
        idle(12);

        // Random valid density and data.
        for (int c = 0; c < 400; c++) cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), acc);
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
